aclk_ui_ctrl: RTL and testbench
===============================

Name: aclk_ui_ctrl

Overview:
- Front-panel controller that configures and sequences the `aclock` core.
- Turns debounced single-cycle button pulses (mode, inc, snooze) into BCD digit values on `H_in*`/`M_in*`, one-cycle `LD_time`/`LD_alarm` strobes and a one-cycle `STOP_al` strobe.
- Keeps a shadow copy of the programmed alarm, because the core does not output it.
- Sits between the panel and `aclock`; its outputs drive the core's load inputs directly.

Parameters:
- TIMEOUT_CYC, 1000, idle cycles in any SET state before the edit is aborted without loading.
- SNOOZE_MIN, 5, minutes added to the current time on snooze; legal range 1..59.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_mode  in  1  one-cycle pulse: advance edit field
- btn_inc  in  1  one-cycle pulse: increment field being edited
- btn_snooze  in  1  one-cycle pulse: snooze a ringing alarm
- Alarm  in  1  ringing indication from `aclock`
- cur_H1  in  2  current time, hour tens digit (from `aclock` `H_out1`)
- cur_H0  in  4  current time, hour units digit
- cur_M1  in  4  current time, minute tens digit
- cur_M0  in  4  current time, minute units digit
- H_in1  out  2  hour tens digit to core
- H_in0  out  4  hour units digit to core
- M_in1  out  4  minute tens digit to core
- M_in0  out  4  minute units digit to core
- LD_time  out  1  one-cycle load-time strobe
- LD_alarm  out  1  one-cycle load-alarm strobe
- STOP_al  out  1  one-cycle stop-alarm strobe
- ui_state  out  4  current FSM state (ui_state_e encoding)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE.
  - All digit outputs, strobes and busy are 0.
  - Alarm shadow = 00:00; timeout counter = 0.
  - Reset mid-edit abandons the edit; no strobe is issued.
- Edit registers eh (BCD 00..23) and em (BCD 00..59) drive `H_in*`/`M_in*` continuously. They are registered and always hold legal BCD.
- States: IDLE, SET_TH, SET_TM, COMMIT_T, SET_AH, SET_AM, COMMIT_A, SNZ_STOP, SNZ_LOAD.
- IDLE:
  - btn_snooze & Alarm → SNZ_STOP.
  - Otherwise btn_mode → SET_TH, loading eh/em from cur_* on the same edge.
  - btn_snooze with Alarm=0 is ignored.
  - Snooze takes priority over mode when both pulse in the same cycle.
- Field progression on btn_mode:
  - SET_TH → SET_TM → COMMIT_T.
  - COMMIT_T lasts 1 cycle, asserts LD_time=1 with the edit values stable, then goes to SET_AH and loads eh/em from the alarm shadow.
  - SET_AH → SET_AM → COMMIT_A.
  - COMMIT_A lasts 1 cycle, asserts LD_alarm=1, writes eh/em into the shadow, then → IDLE.
- btn_inc:
  - In SET_TH/SET_AH: eh += 1, wrapping 23→00 (09→10, 19→20).
  - In SET_TM/SET_AM: em += 1, wrapping 59→00.
  - No carry from minutes into hours.
  - Ignored in other states.
  - btn_mode and btn_inc in the same cycle: mode acts, inc is dropped.
- Timeout:
  - The counter clears on any button pulse or state change.
  - In a SET state, when the counter reaches TIMEOUT_CYC-1 with no button → IDLE. No strobe is issued and the shadow is unchanged.
- btn_snooze is ignored in every SET/COMMIT state.
- Snooze:
  - SNZ_STOP lasts 1 cycle with STOP_al=1.
  - SNZ_LOAD lasts 1 cycle. On entry, eh:em = cur + SNOOZE_MIN mod 24h, computed in BCD with minute carry into hours and 23:xx wrapping to 00:xx. LD_alarm=1 and the shadow is updated.
  - Then → IDLE.
  - Total latency from the btn_snooze cycle: STOP_al is on edge+1, LD_alarm on edge+2.
- Strobes are never asserted together, and each lasts exactly one cycle.
- busy=1 in every state except IDLE.

Decomposition:
- config_pkg gains:
  - typedef enum logic [3:0] ui_state_e.
  - BCD digit typedefs (bcd2_t, bcd4_t) and a time struct {h1,h0,m1,m0}.
  - Constants MAX_HOUR=23 and MAX_MIN=59.
- One sub-module, aclk_bcd_add_min: combinational time + N minutes (N ≤ 59) with 24h wrap. It is reused by the snooze path and is unit-testable on its own.

Test Plan:
- cur=07:45. Pulse mode; inc×3 → 10:45; mode; inc×16 → 10:01; mode → LD_time=1 for exactly 1 cycle with H_in=1,0 and M_in=0,1.
- Continue to SET_AH (shadow 00:00). inc×7 → 07:00; mode; inc×30 → 07:30; mode → LD_alarm=1 with 07:30; state=IDLE, busy=0.
- Alarm=1, cur=23:58. Pulse btn_snooze → STOP_al on the next cycle, LD_alarm the cycle after with 00:03; a later alarm edit shows 00:03.
- Wrap: eh=23 + inc → 00; em=59 + inc → 00 with eh unchanged.
- Timeout: enter SET_TM, no buttons for TIMEOUT_CYC cycles → IDLE, no LD strobe, shadow unchanged. Reset asserted in SET_AM → all outputs 0 on the next edge, shadow 00:00.
- Priority and ignores: btn_snooze with Alarm=0 → no STOP_al. btn_snooze+btn_mode in IDLE with Alarm=1 → snooze path. btn_mode+btn_inc in the same cycle → field advances, value unchanged.

Source files
------------

// File: rtl/aclk_ui_ctrl_pkg.sv
// Shared types and BCD helpers for the aclock front-panel controller.
// States, digit types and time arithmetic used by the UI FSM.
package aclk_ui_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SET_TH   = 4'd1,
        SET_TM   = 4'd2,
        COMMIT_T = 4'd3,
        SET_AH   = 4'd4,
        SET_AM   = 4'd5,
        COMMIT_A = 4'd6,
        SNZ_STOP = 4'd7,
        SNZ_LOAD = 4'd8
    } ui_state_e;

    typedef logic [1:0] bcd2_t;
    typedef logic [3:0] bcd4_t;

    typedef struct packed {
        bcd2_t h1;
        bcd4_t h0;
        bcd4_t m1;
        bcd4_t m0;
    } time_t;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

    function automatic logic [4:0] hour_bin(input time_t t);
        return 5'(t.h1) * 5'd10 + 5'(t.h0);
    endfunction

    function automatic logic [5:0] min_bin(input time_t t);
        return 6'(t.m1) * 6'd10 + 6'(t.m0);
    endfunction

    // Tens digit of a binary value in 0..59.
    function automatic bcd4_t tens_of(input logic [5:0] v);
        bcd4_t r;
        if (v >= 6'd50)      r = 4'd5;
        else if (v >= 6'd40) r = 4'd4;
        else if (v >= 6'd30) r = 4'd3;
        else if (v >= 6'd20) r = 4'd2;
        else if (v >= 6'd10) r = 4'd1;
        else                 r = 4'd0;
        return r;
    endfunction

    function automatic bcd4_t ones_of(input logic [5:0] v);
        logic [5:0] r;
        r = v - 6'(tens_of(v)) * 6'd10;
        return r[3:0];
    endfunction

    function automatic time_t inc_hour(input time_t t);
        time_t r;
        r = t;
        if (hour_bin(t) == 5'(MAX_HOUR)) begin
            r.h1 = '0;
            r.h0 = '0;
        end else if (t.h0 == 4'd9) begin
            r.h1 = t.h1 + 2'd1;
            r.h0 = '0;
        end else begin
            r.h0 = t.h0 + 4'd1;
        end
        return r;
    endfunction

    function automatic time_t inc_min(input time_t t);
        time_t r;
        r = t;
        if (min_bin(t) == 6'(MAX_MIN)) begin
            r.m1 = '0;
            r.m0 = '0;
        end else if (t.m0 == 4'd9) begin
            r.m1 = t.m1 + 4'd1;
            r.m0 = '0;
        end else begin
            r.m0 = t.m0 + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/aclk_bcd_add_min.sv
// Combinational BCD time plus up to 59 minutes, wrapping at 24h.
// Minute overflow carries one hour; 23:xx rolls to 00:xx.
module aclk_bcd_add_min
    import aclk_ui_ctrl_pkg::*;
(
    input  time_t      t,
    input  logic [5:0] n,
    output time_t      sum
);

    logic [6:0] m_sum;
    logic [5:0] m_bin;
    logic [4:0] h_bin;
    logic       carry;

    always_comb begin
        m_sum = 7'(min_bin(t)) + 7'(n);
        carry = m_sum > 7'(MAX_MIN);
        m_bin = carry ? 6'(m_sum - 7'd60) : m_sum[5:0];
        h_bin = hour_bin(t) + 5'(carry);
        if (h_bin > 5'(MAX_HOUR)) begin
            h_bin = '0;
        end
        sum.h1 = 2'(tens_of(6'(h_bin)));
        sum.h0 = ones_of(6'(h_bin));
        sum.m1 = tens_of(m_bin);
        sum.m0 = ones_of(m_bin);
    end

endmodule

// File: rtl/aclk_ui_ctrl.sv
// Front-panel FSM: edits time/alarm digits, issues load/stop strobes,
// and keeps a shadow of the programmed alarm for later editing.
module aclk_ui_ctrl
    import aclk_ui_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       Alarm,
    input  logic [1:0] cur_H1,
    input  logic [3:0] cur_H0,
    input  logic [3:0] cur_M1,
    input  logic [3:0] cur_M0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic [3:0] ui_state,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    ui_state_e     state, state_n;
    time_t         edit, edit_n;
    time_t         shadow, shadow_n;
    time_t         cur, snz_time;
    logic [CW-1:0] tcnt, tcnt_n;
    logic          any_btn, in_set, timeout;

    assign cur = {cur_H1, cur_H0, cur_M1, cur_M0};

    aclk_bcd_add_min u_snz_add (
        .t   (cur),
        .n   (6'(SNOOZE_MIN)),
        .sum (snz_time)
    );

    assign any_btn = btn_mode | btn_inc | btn_snooze;
    assign in_set  = state inside {SET_TH, SET_TM, SET_AH, SET_AM};
    assign timeout = (tcnt == CW'(TIMEOUT_CYC - 1)) && !any_btn;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            edit   <= '0;
            shadow <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            edit   <= edit_n;
            shadow <= shadow_n;
            tcnt   <= tcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        edit_n   = edit;
        shadow_n = shadow;
        unique case (state)
            IDLE: begin
                // Snooze wins over mode when both arrive together.
                if (btn_snooze && Alarm) begin
                    state_n = SNZ_STOP;
                end else if (btn_mode) begin
                    state_n = SET_TH;
                    edit_n  = cur;
                end
            end
            SET_TH, SET_AH: begin
                if (btn_mode) begin
                    state_n = (state == SET_TH) ? SET_TM : SET_AM;
                end else if (btn_inc) begin
                    edit_n = inc_hour(edit);
                end else if (timeout) begin
                    state_n = IDLE;
                end
            end
            SET_TM, SET_AM: begin
                if (btn_mode) begin
                    state_n = (state == SET_TM) ? COMMIT_T : COMMIT_A;
                end else if (btn_inc) begin
                    edit_n = inc_min(edit);
                end else if (timeout) begin
                    state_n = IDLE;
                end
            end
            COMMIT_T: begin
                state_n = SET_AH;
                edit_n  = shadow;
            end
            COMMIT_A, SNZ_LOAD: begin
                state_n  = IDLE;
                shadow_n = edit;
            end
            SNZ_STOP: begin
                state_n = SNZ_LOAD;
                edit_n  = snz_time;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        tcnt_n = (in_set && state_n == state && !any_btn) ? tcnt + CW'(1) : '0;
    end

    assign H_in1    = edit.h1;
    assign H_in0    = edit.h0;
    assign M_in1    = edit.m1;
    assign M_in0    = edit.m0;
    assign LD_time  = (state == COMMIT_T);
    assign LD_alarm = (state == COMMIT_A) || (state == SNZ_LOAD);
    assign STOP_al  = (state == SNZ_STOP);
    assign ui_state = state;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_aclk_ui_ctrl.sv
// Bench for aclk_ui_ctrl: directed scenarios plus randomized buttons
// compared against a minutes-of-day reference model.
module tb_aclk_ui_ctrl;

    localparam int TO  = 20;
    localparam int SNZ = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_snooze = 1'b0;
    logic       Alarm = 1'b0;
    logic [1:0] cur_H1 = '0;
    logic [3:0] cur_H0 = '0, cur_M1 = '0, cur_M0 = '0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, STOP_al, busy;
    logic [3:0] ui_state;
    logic [13:0] dig;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase follows the listed state order, times as ints.
    int ph = 0, eh = 0, em = 0, shadow = 0, cnt = 0;
    int cur_h = 0, cur_m = 0;

    always #5 clk = ~clk;

    assign dig = {H_in1, H_in0, M_in1, M_in0};

    aclk_ui_ctrl #(.TIMEOUT_CYC(TO), .SNOOZE_MIN(SNZ)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_snooze (btn_snooze),
        .Alarm      (Alarm),
        .cur_H1     (cur_H1),
        .cur_H0     (cur_H0),
        .cur_M1     (cur_M1),
        .cur_M0     (cur_M0),
        .H_in1      (H_in1),
        .H_in0      (H_in0),
        .M_in1      (M_in1),
        .M_in0      (M_in0),
        .LD_time    (LD_time),
        .LD_alarm   (LD_alarm),
        .STOP_al    (STOP_al),
        .ui_state   (ui_state),
        .busy       (busy)
    );

    function automatic logic [13:0] bcd(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic set_cur(input int h, input int m);
        cur_h  = h;
        cur_m  = m;
        cur_H1 = 2'(h / 10);
        cur_H0 = 4'(h % 10);
        cur_M1 = 4'(m / 10);
        cur_M0 = 4'(m % 10);
    endtask

    task automatic mdl_reset();
        ph = 0; eh = 0; em = 0; shadow = 0; cnt = 0;
    endtask

    task automatic mdl(input bit m, input bit i, input bit s);
        int nph;
        int t;
        bit set_ph;
        nph = ph;
        set_ph = (ph == 1 || ph == 2 || ph == 4 || ph == 5);
        case (ph)
            0: begin
                if (s && Alarm) nph = 7;
                else if (m) begin nph = 1; eh = cur_h; em = cur_m; end
            end
            1, 4: begin
                if (m) nph = ph + 1;
                else if (i) eh = (eh + 1) % 24;
                else if (!s && cnt == TO - 1) nph = 0;
            end
            2, 5: begin
                if (m) nph = ph + 1;
                else if (i) em = (em + 1) % 60;
                else if (!s && cnt == TO - 1) nph = 0;
            end
            3: begin nph = 4; eh = shadow / 60; em = shadow % 60; end
            6, 8: begin shadow = eh * 60 + em; nph = 0; end
            7: begin
                t = (cur_h * 60 + cur_m + SNZ) % 1440;
                eh = t / 60; em = t % 60; nph = 8;
            end
            default: ;
        endcase
        cnt = (set_ph && nph == ph && !(m || i || s)) ? cnt + 1 : 0;
        ph = nph;
    endtask

    task automatic tick(input bit m, input bit i, input bit s);
        btn_mode = m; btn_inc = i; btn_snooze = s;
        @(posedge clk);
        if (reset) mdl_reset();
        else mdl(m, i, s);
        #1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(0, 0, 0);
        tick(0, 0, 0);
        reset = 1'b0;
        n_cmp++;
        if (dig !== 14'd0) begin n_err++; $display("FAIL reset_digits got %h want 0", dig); end
        n_cmp++;
        if ({LD_time, LD_alarm, STOP_al} !== 3'b000) begin
            n_err++; $display("FAIL reset_strobes got %b want 000", {LD_time, LD_alarm, STOP_al});
        end
        n_cmp++;
        if (busy !== 1'b0 || ui_state !== 4'd0) begin
            n_err++; $display("FAIL reset_state got busy=%b st=%0d want 0/0", busy, ui_state);
        end
    endtask

    task automatic test_time_edit();
        Alarm = 1'b0;
        set_cur(7, 45);
        tick(1, 0, 0);
        repeat (3) tick(0, 1, 0);
        n_cmp++;
        if (dig !== bcd(10, 45) || ui_state !== 4'd1) begin
            n_err++; $display("FAIL time_hour got %h st=%0d want %h st=1", dig, ui_state, bcd(10, 45));
        end
        tick(1, 0, 0);
        repeat (16) tick(0, 1, 0);
        n_cmp++;
        if (dig !== bcd(10, 1)) begin n_err++; $display("FAIL time_min got %h want %h", dig, bcd(10, 1)); end
        tick(1, 0, 0);
        n_cmp++;
        if (LD_time !== 1'b1 || LD_alarm !== 1'b0 || dig !== bcd(10, 1)) begin
            n_err++; $display("FAIL ld_time got ld=%b la=%b %h want 1/0 %h", LD_time, LD_alarm, dig, bcd(10, 1));
        end
        tick(0, 0, 0);
        n_cmp++;
        if (LD_time !== 1'b0 || ui_state !== 4'd4 || dig !== bcd(0, 0)) begin
            n_err++; $display("FAIL to_set_ah got ld=%b st=%0d %h want 0 4 0000", LD_time, ui_state, dig);
        end
    endtask

    task automatic test_alarm_edit();
        repeat (7) tick(0, 1, 0);
        tick(1, 0, 0);
        repeat (30) tick(0, 1, 0);
        tick(1, 0, 0);
        n_cmp++;
        if (LD_alarm !== 1'b1 || LD_time !== 1'b0 || dig !== bcd(7, 30)) begin
            n_err++; $display("FAIL ld_alarm got la=%b lt=%b %h want 1/0 %h", LD_alarm, LD_time, dig, bcd(7, 30));
        end
        tick(0, 0, 0);
        n_cmp++;
        if (ui_state !== 4'd0 || busy !== 1'b0 || LD_alarm !== 1'b0) begin
            n_err++; $display("FAIL alarm_idle got st=%0d busy=%b la=%b want 0/0/0", ui_state, busy, LD_alarm);
        end
    endtask

    task automatic test_snooze();
        Alarm = 1'b1;
        set_cur(23, 58);
        tick(0, 0, 1);
        n_cmp++;
        if (STOP_al !== 1'b1 || LD_alarm !== 1'b0 || ui_state !== 4'd7) begin
            n_err++; $display("FAIL snz_stop got stop=%b la=%b st=%0d want 1/0/7", STOP_al, LD_alarm, ui_state);
        end
        tick(0, 0, 0);
        n_cmp++;
        if (STOP_al !== 1'b0 || LD_alarm !== 1'b1 || dig !== bcd(0, 3)) begin
            n_err++; $display("FAIL snz_load got stop=%b la=%b %h want 0/1 %h", STOP_al, LD_alarm, dig, bcd(0, 3));
        end
        tick(0, 0, 0);
        Alarm = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || LD_alarm !== 1'b0) begin
            n_err++; $display("FAIL snz_idle got busy=%b la=%b want 0/0", busy, LD_alarm);
        end
        tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        n_cmp++;
        if (ui_state !== 4'd4 || dig !== bcd(0, 3)) begin
            n_err++; $display("FAIL snz_shadow got st=%0d %h want 4 %h", ui_state, dig, bcd(0, 3));
        end
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
    endtask

    task automatic test_wrap_timeout_reset();
        bit bad;
        set_cur(23, 59);
        tick(1, 0, 0);
        tick(0, 1, 0);
        n_cmp++;
        if (dig !== bcd(0, 59)) begin n_err++; $display("FAIL hour_wrap got %h want %h", dig, bcd(0, 59)); end
        tick(1, 0, 0);
        tick(0, 1, 0);
        n_cmp++;
        if (dig !== bcd(0, 0)) begin n_err++; $display("FAIL min_wrap got %h want %h", dig, bcd(0, 0)); end
        bad = 1'b0;
        for (int k = 0; k < TO - 1; k++) begin
            tick(0, 0, 0);
            if (ui_state !== 4'd2 || LD_time !== 1'b0 || LD_alarm !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin n_err++; $display("FAIL timeout_early got st=%0d want 2 until expiry", ui_state); end
        tick(0, 0, 0);
        n_cmp++;
        if (ui_state !== 4'd0 || LD_time !== 1'b0 || LD_alarm !== 1'b0) begin
            n_err++; $display("FAIL timeout_idle got st=%0d lt=%b la=%b want 0/0/0", ui_state, LD_time, LD_alarm);
        end
        tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        n_cmp++;
        if (dig !== bcd(0, 3)) begin n_err++; $display("FAIL timeout_shadow got %h want %h", dig, bcd(0, 3)); end
        tick(1, 0, 0);
        reset = 1'b1;
        tick(0, 0, 0);
        reset = 1'b0;
        n_cmp++;
        if ({dig, LD_time, LD_alarm, STOP_al, busy, ui_state} !== 22'd0) begin
            n_err++; $display("FAIL reset_mid_edit got %h st=%0d busy=%b want all 0", dig, ui_state, busy);
        end
        tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        n_cmp++;
        if (ui_state !== 4'd4 || dig !== bcd(0, 0)) begin
            n_err++; $display("FAIL reset_shadow got st=%0d %h want 4 0000", ui_state, dig);
        end
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
    endtask

    task automatic test_priority();
        Alarm = 1'b0;
        tick(0, 0, 1);
        n_cmp++;
        if (STOP_al !== 1'b0 || ui_state !== 4'd0) begin
            n_err++; $display("FAIL snz_no_alarm got stop=%b st=%0d want 0/0", STOP_al, ui_state);
        end
        Alarm = 1'b1;
        tick(1, 0, 1);
        n_cmp++;
        if (STOP_al !== 1'b1 || ui_state !== 4'd7) begin
            n_err++; $display("FAIL snz_over_mode got stop=%b st=%0d want 1/7", STOP_al, ui_state);
        end
        tick(0, 0, 0); tick(0, 0, 0);
        Alarm = 1'b0;
        set_cur(12, 34);
        tick(1, 0, 0);
        tick(1, 1, 0);
        n_cmp++;
        if (ui_state !== 4'd2 || dig !== bcd(12, 34)) begin
            n_err++; $display("FAIL mode_over_inc got st=%0d %h want 2 %h", ui_state, dig, bcd(12, 34));
        end
        tick(1, 0, 0); tick(0, 0, 0); tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
    endtask

    task automatic test_random();
        int dens;
        int shown;
        bit m, i, s;
        shown = 0;
        for (int k = 0; k < 3000; k++) begin
            dens = (k < 1500) ? 4 : 40;
            if (ph == 0 && $urandom_range(7) == 0) set_cur($urandom_range(23), $urandom_range(59));
            if ($urandom_range(15) == 0) Alarm = ~Alarm;
            m = ($urandom_range(dens - 1) == 0);
            i = ($urandom_range(dens - 1) == 0);
            s = ($urandom_range(dens - 1) == 0);
            reset = ($urandom_range(499) == 0);
            tick(m, i, s);
            reset = 1'b0;
            n_cmp++;
            if (ui_state !== 4'(ph) || dig !== bcd(eh, em) || LD_time !== (ph == 3) ||
                LD_alarm !== (ph == 6 || ph == 8) || STOP_al !== (ph == 7) || busy !== (ph != 0)) begin
                n_err++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cyc=%0d got st=%0d %h lt=%b la=%b sa=%b want st=%0d %h",
                             k, ui_state, dig, LD_time, LD_alarm, STOP_al, ph, bcd(eh, em));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_time_edit();
        test_alarm_edit();
        test_snooze();
        test_wrap_timeout_reset();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
